// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester, ROM and response signals of the shared sprite ROM port
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 9
);
  localparam int ID_W = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_address;
  logic [DATA_W-1:0]         rom_q;
  logic                      rsp_valid;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;
  logic                      busy;
  modport master (
    output req, req_addr, req_last, req_lock, rom_q,
    input  gnt, rom_address, rsp_valid, rsp_id, rsp_data, busy
  );
  modport slave (
    input  req, req_addr, req_last, req_lock, rom_q,
    output gnt, rom_address, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite ROM read port with locked row bursts
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 9,
  parameter int ROM_LAT = 1
) (
  input logic vga_clk,
  input logic reset_n,
  sprite_rom_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t             r_state;
  logic [ID_W-1:0]    r_ptr;
  logic [ID_W-1:0]    r_owner;
  logic [ROM_LAT-1:0] r_pv;
  logic [ID_W-1:0]    r_pid [ROM_LAT];
  logic [ID_W-1:0]    w_sel;
  logic [ID_W-1:0]    w_idx;
  logic               w_any;
  logic               w_acc;
  // Scan downward so the last hit is the nearest requester after r_ptr.
  always_comb begin
    w_sel = r_owner;
    w_idx = '0;
    w_any = 1'b0;
    if (r_state == LOCKED) w_any = bus.req[r_owner];
    else
      for (int k = NUM_REQ; k >= 1; k--) begin
        w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
        if (bus.req[w_idx]) begin
          w_sel = w_idx;
          w_any = 1'b1;
        end
      end
  end
  assign w_acc   = reset_n && w_any;
  assign bus.gnt = w_acc ? NUM_REQ'(1) << w_sel : '0;
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_ptr           <= ID_W'(NUM_REQ - 1);
      r_owner         <= '0;
      r_pv            <= '0;
      bus.busy        <= 1'b0;
      bus.rom_address <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_id      <= '0;
      bus.rsp_data    <= '0;
      for (int s = 0; s < ROM_LAT; s++) r_pid[s] <= '0;
    end else begin
      if (w_acc) begin
        r_ptr           <= w_sel;
        bus.rom_address <= bus.req_addr[w_sel*ADDR_W +: ADDR_W];
        if (r_state == IDLE && bus.req_lock[w_sel] && !bus.req_last[w_sel]) begin
          r_state  <= LOCKED;
          r_owner  <= w_sel;
          bus.busy <= 1'b1;
        end else if (r_state == LOCKED && bus.req_last[w_sel]) begin
          r_state  <= IDLE;
          bus.busy <= 1'b0;
        end
      end
      r_pv[0]  <= w_acc;
      r_pid[0] <= w_sel;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
      bus.rsp_valid <= r_pv[ROM_LAT-1];
      if (r_pv[ROM_LAT-1]) begin
        bus.rsp_id   <= r_pid[ROM_LAT-1];
        bus.rsp_data <= bus.rom_q;
      end
    end
  end
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: drives two arbiters (ROM latency 1 and 3) with identical requests and scoreboards their responses
module tb_sprite_rom_arbiter;
  localparam int N  = 4;
  localparam int AW = 12;
  localparam int DW = 9;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always #5 vga_clk = ~vga_clk;
  always @(posedge vga_clk) cyc <= cyc + 1;
  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) b1 ();
  sprite_rom_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) b3 ();
  assign b1.req = req;      assign b3.req = req;
  assign b1.req_addr = req_addr; assign b3.req_addr = req_addr;
  assign b1.req_last = req_last; assign b3.req_last = req_last;
  assign b1.req_lock = req_lock; assign b3.req_lock = req_lock;
  // ROM models: latency 1 is combinational on the address, latency 3 adds two address stages.
  logic [AW-1:0] d1, d2;
  always @(posedge vga_clk) begin
    d1 <= b3.rom_address;
    d2 <= d1;
  end
  assign b1.rom_q = DW'(b1.rom_address) ^ 9'h1A5;
  assign b3.rom_q = DW'(d2) ^ 9'h1A5;
  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(b1.slave));
  sprite_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LAT(3)) dut3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .bus(b3.slave));
  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t q1[$], q3[$];
  exp_t e1, e3;
  // Called in the cycle before the accepting edge.
  task automatic push(input int id, input logic [AW-1:0] a);
    exp_t e;
    e.id   = 2'(id);
    e.data = DW'(a) ^ 9'h1A5;
    e.cyc  = cyc + 2;
    q1.push_back(e);
    e.cyc  = cyc + 4;
    q3.push_back(e);
  endtask
  always @(negedge vga_clk) begin
    if (b1.rsp_valid) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_lat1_unexpected: got id=%0d data=%h cyc=%0d, required no response", b1.rsp_id, b1.rsp_data, cyc);
      end else begin
        e1 = q1.pop_front();
        if (b1.rsp_id !== e1.id || b1.rsp_data !== e1.data || cyc != e1.cyc) begin
          n_fail++;
          $display("FAIL rsp_lat1: got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", b1.rsp_id, b1.rsp_data, cyc, e1.id, e1.data, e1.cyc);
        end
      end
    end
    if (b3.rsp_valid) begin
      n_checks++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_lat3_unexpected: got id=%0d data=%h cyc=%0d, required no response", b3.rsp_id, b3.rsp_data, cyc);
      end else begin
        e3 = q3.pop_front();
        if (b3.rsp_id !== e3.id || b3.rsp_data !== e3.data || cyc != e3.cyc) begin
          n_fail++;
          $display("FAIL rsp_lat3: got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d", b3.rsp_id, b3.rsp_data, cyc, e3.id, e3.data, e3.cyc);
        end
      end
    end
  end
  task automatic test_reset();
    reset_n = 1'b0;
    req = '1;
    repeat (2) @(posedge vga_clk);
    @(negedge vga_clk);
    n_checks++;
    if (b1.gnt !== 4'b0000 || b3.gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gnt: got %b/%b, required 0000", b1.gnt, b3.gnt);
    end
    n_checks++;
    if (b1.rom_address !== 12'd0 || b1.rsp_valid !== 1'b0 || b1.rsp_id !== 2'd0 || b1.rsp_data !== 9'd0 || b1.busy !== 1'b0 ||
        b3.rom_address !== 12'd0 || b3.rsp_valid !== 1'b0 || b3.rsp_id !== 2'd0 || b3.rsp_data !== 9'd0 || b3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h/%h valid=%b/%b id=%0d/%0d data=%h/%h busy=%b/%b, required all zero",
               b1.rom_address, b3.rom_address, b1.rsp_valid, b3.rsp_valid, b1.rsp_id, b3.rsp_id, b1.rsp_data, b3.rsp_data, b1.busy, b3.busy);
    end
    req = '0;
    reset_n = 1'b1;
  endtask
  task automatic test_round_robin();
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(i * 16);
    for (int t = 0; t < 5; t++) begin
      @(negedge vga_clk);
      req = '1;
      #1;
      eg = N'(1) << (t % N);
      n_checks++;
      if (b1.gnt !== eg || b3.gnt !== eg) begin
        n_fail++;
        $display("FAIL rr_gnt beat %0d: got %b/%b, required %b", t, b1.gnt, b3.gnt, eg);
      end
      push(t % N, AW'((t % N) * 16));
      @(posedge vga_clk);
      #1;
      n_checks++;
      if (b1.rom_address !== AW'((t % N) * 16) || b3.rom_address !== AW'((t % N) * 16)) begin
        n_fail++;
        $display("FAIL rr_addr beat %0d: got %0d/%0d, required %0d", t, b1.rom_address, b3.rom_address, (t % N) * 16);
      end
    end
    @(negedge vga_clk);
    req = '0;
    repeat (6) @(negedge vga_clk);
  endtask
  task automatic test_lock();
    @(negedge vga_clk);
    req = 4'b0010;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b0010 || b3.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL lock_pre_gnt: got %b/%b, required 0010", b1.gnt, b3.gnt);
    end
    push(1, 12'd16);
    for (int b = 0; b < 4; b++) begin
      @(negedge vga_clk);
      req = '1;
      req_lock = 4'b0100;
      req_last = (b == 3) ? 4'b0100 : 4'b0000;
      req_addr[2*AW +: AW] = AW'(100 + b);
      #1;
      n_checks++;
      if (b1.gnt !== 4'b0100 || b3.gnt !== 4'b0100) begin
        n_fail++;
        $display("FAIL lock_gnt beat %0d: got %b/%b, required 0100", b, b1.gnt, b3.gnt);
      end
      push(2, AW'(100 + b));
      @(posedge vga_clk);
      #1;
      n_checks++;
      if (b1.busy !== (b < 3) || b3.busy !== (b < 3) || b1.rom_address !== AW'(100 + b)) begin
        n_fail++;
        $display("FAIL lock_busy beat %0d: got busy=%b/%b addr=%0d, required busy=%b addr=%0d", b, b1.busy, b3.busy, b1.rom_address, b < 3, 100 + b);
      end
    end
    @(negedge vga_clk);
    req_lock = '0;
    req_last = '0;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b1000 || b3.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL lock_after_gnt: got %b/%b, required 1000", b1.gnt, b3.gnt);
    end
    req = '0;
    repeat (6) @(negedge vga_clk);
  endtask
  task automatic test_lock_gap();
    for (int b = 0; b < 2; b++) begin
      @(negedge vga_clk);
      req = '1;
      req_lock = 4'b1000;
      req_addr[3*AW +: AW] = AW'(200 + b);
      #1;
      n_checks++;
      if (b1.gnt !== 4'b1000 || b3.gnt !== 4'b1000) begin
        n_fail++;
        $display("FAIL gap_gnt beat %0d: got %b/%b, required 1000", b, b1.gnt, b3.gnt);
      end
      push(3, AW'(200 + b));
      @(posedge vga_clk);
    end
    for (int g = 0; g < 3; g++) begin
      @(negedge vga_clk);
      req = 4'b0111;
      #1;
      n_checks++;
      if (b1.gnt !== 4'b0000 || b3.gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL gap_blocked cycle %0d: got %b/%b, required 0000", g, b1.gnt, b3.gnt);
      end
      @(posedge vga_clk);
      #1;
      n_checks++;
      if (b1.busy !== 1'b1 || b3.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL gap_busy cycle %0d: got %b/%b, required 1", g, b1.busy, b3.busy);
      end
    end
    @(negedge vga_clk);
    req = '1;
    req_last = 4'b1000;
    req_addr[3*AW +: AW] = 12'd202;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b1000 || b3.gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL gap_resume_gnt: got %b/%b, required 1000", b1.gnt, b3.gnt);
    end
    push(3, 12'd202);
    @(posedge vga_clk);
    #1;
    n_checks++;
    if (b1.busy !== 1'b0 || b3.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL gap_end_busy: got %b/%b, required 0", b1.busy, b3.busy);
    end
    @(negedge vga_clk);
    req_lock = '0;
    req_last = '0;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b0001 || b3.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL gap_after_gnt: got %b/%b, required 0001", b1.gnt, b3.gnt);
    end
    req = '0;
    repeat (6) @(negedge vga_clk);
  endtask
  task automatic test_back_to_back();
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    for (int t = 0; t < 4; t++) begin
      @(negedge vga_clk);
      req = 4'b0101;
      req_addr[0 +: AW]    = AW'(12'h0AB + t);
      req_addr[2*AW +: AW] = AW'(12'h3C7 + t);
      #1;
      eg = (t % 2 == 1) ? 4'b0100 : 4'b0001;
      a  = (t % 2 == 1) ? AW'(12'h3C7 + t) : AW'(12'h0AB + t);
      n_checks++;
      if (b1.gnt !== eg || b3.gnt !== eg) begin
        n_fail++;
        $display("FAIL b2b_gnt beat %0d: got %b/%b, required %b", t, b1.gnt, b3.gnt, eg);
      end
      push((t % 2 == 1) ? 2 : 0, a);
      @(posedge vga_clk);
      #1;
      n_checks++;
      if (b3.rom_address !== a) begin
        n_fail++;
        $display("FAIL b2b_addr beat %0d: got %h, required %h", t, b3.rom_address, a);
      end
    end
    @(negedge vga_clk);
    req = '0;
    repeat (8) @(negedge vga_clk);
  endtask
  task automatic test_reset_inflight();
    @(negedge vga_clk);
    req = 4'b0010;
    req_lock = 4'b0010;
    req_addr[AW +: AW] = 12'h077;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b0010 || b3.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rst_lock_gnt: got %b/%b, required 0010", b1.gnt, b3.gnt);
    end
    @(posedge vga_clk);
    #1;
    n_checks++;
    if (b1.busy !== 1'b1 || b3.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_lock_busy: got %b/%b, required 1", b1.busy, b3.busy);
    end
    @(negedge vga_clk);
    reset_n = 1'b0;
    req = '0;
    req_lock = '0;
    @(posedge vga_clk);
    #1;
    n_checks++;
    if (b1.busy !== 1'b0 || b3.busy !== 1'b0 || b1.rsp_valid !== 1'b0 || b3.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_flush: got busy=%b/%b valid=%b/%b, required 0", b1.busy, b3.busy, b1.rsp_valid, b3.rsp_valid);
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    req = '1;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b0001 || b3.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL rst_next_gnt: got %b/%b, required 0001", b1.gnt, b3.gnt);
    end
    req = '0;
    repeat (6) @(negedge vga_clk);
  endtask
  task automatic test_single_lock_last();
    @(negedge vga_clk);
    req = 4'b0010;
    req_lock = 4'b0010;
    req_last = 4'b0010;
    req_addr[AW +: AW] = 12'h055;
    #1;
    n_checks++;
    if (b1.gnt !== 4'b0010 || b3.gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_gnt: got %b/%b, required 0010", b1.gnt, b3.gnt);
    end
    push(1, 12'h055);
    @(negedge vga_clk);
    req = '0;
    req_lock = '0;
    req_last = '0;
    for (int c = 0; c < 4; c++) begin
      @(posedge vga_clk);
      #1;
      n_checks++;
      if (b1.busy !== 1'b0 || b3.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL single_busy cycle %0d: got %b/%b, required 0", c, b1.busy, b3.busy);
      end
    end
    repeat (4) @(negedge vga_clk);
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_lock_gap();
    test_back_to_back();
    q1.delete();
    q3.delete();
    test_reset_inflight();
    test_single_lock_last();
    n_checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d responses outstanding, required 0", q1.size(), q3.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Shares one sprite ROM read port between up to NUM_REQ sprite renderers, such as the brick background, player and ball layers, that would otherwise each need a private ROM copy. Each requester presents an address and waits for a one-hot grant. Requesters are served round-robin, with optional locked bursts for row fetches. Every accepted read returns the ROM word tagged with the requester's ID after a fixed latency. The block sits between the per-layer sprite engines and the shared ROM/palette pair in the VGA clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 12, ROM address width
- DATA_W, 9, ROM word (palette index) width
- ROM_LAT, 1, vga_clk edges from rom_address update to rom_q being valid for sampling (1..4)
- vga_clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  per-requester read request; held until granted
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_last  in  NUM_REQ  marks the final beat of a locked burst
- req_lock  in  NUM_REQ  requests burst lock; sampled on the first accepted beat only
- gnt  out  NUM_REQ  one-hot grant, combinational from req and state; at most one bit set
- rom_address  out  ADDR_W  registered address to the shared ROM
- rom_q  in  DATA_W  ROM data
- rsp_valid  out  1  registered; response word valid this cycle
- rsp_id  out  $clog2(NUM_REQ)  registered; requester index of the response
- rsp_data  out  DATA_W  registered; ROM word
- busy  out  1  registered; high while in LOCKED state

## Operation
- A beat is accepted at a rising edge when req[i] and gnt[i] are both high during the preceding cycle.
- State machine has two states, IDLE and LOCKED.
- IDLE: gnt goes to the first set req bit scanning upward from rr_ptr+1 (mod NUM_REQ), wrapping. No req set means gnt = 0.
- IDLE, beat accepted from i:
  - rr_ptr <= i.
  - If req_lock[i]=1 and req_last[i]=0: go to LOCKED, owner <= i, busy <= 1.
- LOCKED: gnt = req[owner] ? onehot(owner) : 0, and all other requesters are blocked.
  - An accepted beat with req_last[owner]=1 returns to IDLE and clears busy.
  - rr_ptr stays at owner, so the next arbitration starts after it.
- Gaps inside a lock (req[owner] low) hold LOCKED indefinitely; no timeout.
- Each accepted beat:
  - rom_address <= selected req_addr.
  - A {valid, id} token enters a ROM_LAT-deep shift pipeline.
- Token at pipeline output at edge k+ROM_LAT:
  - rsp_valid <= 1, rsp_id <= id, rsp_data <= rom_q.
  - Otherwise rsp_valid <= 0; rsp_id and rsp_data hold their last value.
- Throughput is one beat per cycle. Back-to-back beats from different requesters are allowed in IDLE.
- Responses return in acceptance order. There is no response backpressure; consumers must take rsp_* in the valid cycle.
- req_lock=1 with req_last=1 on the first beat is a single beat and stays in IDLE.
- A requester dropping req without a grant is legal; nothing is recorded.

## Timing
- Reset (reset_n low at a rising edge):
  - rom_address=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - State IDLE, rr_ptr=NUM_REQ-1, so requester 0 wins first.
  - All pipeline tokens are cleared.
- gnt is combinationally 0 while reset_n is low.
- Reset mid-burst or with reads in flight drops those responses silently. No rsp_valid is asserted after reset for pre-reset beats.
- Latency: beat accepted at edge k gives rom_address valid after edge k and rsp_valid high in the cycle after edge k+ROM_LAT.
- With ROM_LAT=1 and the ROM clocked on ~vga_clk, the ROM output settles mid-cycle and is sampled at edge k+1.
- Arbitration and lock decisions use only registered state plus current req/req_lock/req_last. There is no combinational path from rom_q to gnt.

## Test plan
- Reset, then req=4'b1111 held with addr_i=i*16 -> grants 0,1,2,3,0 on consecutive cycles; rom_address = 0,16,32,48,0; rsp_id sequence 0,1,2,3 starting one cycle later (ROM_LAT=1).
- Requester 2 issues lock, 4 beats at addr 100..103 with last on beat 4, while req 0,1,3 are held high -> gnt=4'b0100 for 4 cycles, busy high for cycles 2..4, then grant to requester 3.
- Locked owner drops req for 3 cycles mid-burst -> gnt=0 for those cycles, other requesters stay blocked, busy stays 1; the burst resumes and completes.
- ROM model with ROM_LAT=3, data=addr^9'h1A5 -> each rsp_data matches and appears exactly 3 cycles after rom_address changes, in acceptance order.
- reset_n low for one edge while 1 beat is in flight and a lock is held -> no rsp_valid for that beat, busy=0, next grant to requester 0.
- Only requester 1 requesting with lock=1 and last=1 -> single beat, busy never asserts, rsp_id=1.
